// File: rtl/mem_ctrl_linebuf_if.sv
// CPU word port and host cache-line port of the line-buffer memory controller.
// The controller takes the slave view; the cpu/host environment takes the master view.
interface mem_ctrl_linebuf_if #(
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned CL_SIZE_WIDTH = 512
);
  logic                     host_init;
  logic [1:0]               op;
  logic [ADDR_BITCOUNT-1:0] raw_address;
  logic [ADDR_BITCOUNT-1:0] address_offset;
  logic [WORD_SIZE-1:0]     common_data_bus_write_out;
  logic [WORD_SIZE-1:0]     common_data_bus_read_in;
  logic                     ready;
  logic                     tx_done;
  logic                     rd_valid;
  logic                     host_rd_ready;
  logic                     host_wr_ready;
  logic                     host_rd_valid;
  logic                     host_re;
  logic                     host_we;
  logic [ADDR_BITCOUNT-1:0] corrected_address;
  logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in;
  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out;

  modport slave (
    input  host_init, op, raw_address, address_offset, common_data_bus_write_out,
    input  host_rd_ready, host_wr_ready, host_rd_valid, host_data_bus_read_in,
    output common_data_bus_read_in, ready, tx_done, rd_valid,
    output host_re, host_we, corrected_address, host_data_bus_write_out
  );

  modport master (
    output host_init, op, raw_address, address_offset, common_data_bus_write_out,
    output host_rd_ready, host_wr_ready, host_rd_valid, host_data_bus_read_in,
    input  common_data_bus_read_in, ready, tx_done, rd_valid,
    input  host_re, host_we, corrected_address, host_data_bus_write_out
  );
endinterface

// File: rtl/mem_ctrl_linebuf.sv
// Single-line write-back, write-allocate buffer between the cpu word port and the host line port.
// Hits complete locally; misses write back a dirty line, then fill; flush writes back only.
module mem_ctrl_linebuf #(
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned CL_SIZE_WIDTH = 512
) (
  input logic              clk,
  input logic              rst_n,
  mem_ctrl_linebuf_if.slave bus
);
  localparam int unsigned AW         = ADDR_BITCOUNT;
  localparam int unsigned WW         = WORD_SIZE;
  localparam int unsigned LW         = CL_SIZE_WIDTH;
  localparam int unsigned OFF_BITS   = $clog2(LW / 8);
  localparam int unsigned SUB_BITS   = $clog2(WW / 8);
  localparam int unsigned WORD_SHIFT = $clog2(WW);
  localparam int unsigned POS_BITS   = $clog2(LW);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        line_q;
  logic [AW-1:0]        tag_q;
  logic                 valid_q, dirty_q;
  logic [AW-1:0]        req_tag_q;
  logic [POS_BITS-1:0]  req_pos_q;
  logic [1:0]           op_q;
  logic [WW-1:0]        wdata_q;

  logic [AW-1:0]        eff_c, tag_c;
  logic [POS_BITS-1:0]  pos_c;
  logic                 hit_c, accept_c;
  logic                 unused_eff;

  // Effective address wraps modulo 2^AW; sub-word bits only feed the parity sink.
  assign eff_c      = bus.raw_address + bus.address_offset;
  assign tag_c      = {eff_c[AW-1:OFF_BITS], OFF_BITS'(0)};
  assign pos_c      = {eff_c[OFF_BITS-1:SUB_BITS], WORD_SHIFT'(0)};
  assign hit_c      = valid_q && (tag_q == tag_c);
  assign accept_c   = (state_q == S_READY) && (bus.op != OP_NOP);
  assign unused_eff = ^eff_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (bus.host_init) state_d = S_READY;
      S_READY: begin
        if (accept_c) begin
          if (bus.op == OP_FLUSH) state_d = (valid_q && dirty_q) ? S_WB : S_RESP;
          else if (hit_c)         state_d = S_RESP;
          else if (dirty_q)       state_d = S_WB;
          else                    state_d = S_FILL_REQ;
        end
      end
      S_WB:        if (bus.host_wr_ready) state_d = (op_q == OP_FLUSH) ? S_RESP : S_FILL_REQ;
      S_FILL_REQ:  if (bus.host_rd_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (bus.host_rd_valid) state_d = S_RESP;
      S_RESP:      state_d = S_READY;
      default:     state_d = S_IDLE;
    endcase
  end

  // Line storage, request latches and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q                      <= '0;
      tag_q                       <= '0;
      valid_q                     <= 1'b0;
      dirty_q                     <= 1'b0;
      req_tag_q                   <= '0;
      req_pos_q                   <= '0;
      op_q                        <= OP_NOP;
      wdata_q                     <= '0;
      bus.ready                   <= 1'b0;
      bus.tx_done                 <= 1'b0;
      bus.rd_valid                <= 1'b0;
      bus.common_data_bus_read_in <= '0;
      bus.host_re                 <= 1'b0;
      bus.host_we                 <= 1'b0;
      bus.corrected_address       <= '0;
      bus.host_data_bus_write_out <= '0;
    end else begin
      bus.ready    <= (state_d == S_READY);
      bus.tx_done  <= (state_d == S_RESP);
      bus.rd_valid <= 1'b0;
      bus.host_re  <= 1'b0;
      bus.host_we  <= 1'b0;
      unique case (state_q)
        S_READY: begin
          if (accept_c) begin
            req_tag_q <= tag_c;
            req_pos_q <= pos_c;
            op_q      <= bus.op;
            wdata_q   <= bus.common_data_bus_write_out;
            if (hit_c && bus.op == OP_READ) begin
              bus.common_data_bus_read_in <= line_q[pos_c +: WW];
              bus.rd_valid                <= 1'b1;
            end else if (hit_c && bus.op == OP_WRITE) begin
              line_q[pos_c +: WW] <= bus.common_data_bus_write_out;
              dirty_q             <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (bus.host_wr_ready) begin
            bus.host_we                 <= 1'b1;
            bus.corrected_address       <= tag_q;
            bus.host_data_bus_write_out <= line_q;
            dirty_q                     <= 1'b0;
          end
        end
        S_FILL_REQ: begin
          if (bus.host_rd_ready) begin
            bus.host_re           <= 1'b1;
            bus.corrected_address <= req_tag_q;
          end
        end
        S_FILL_WAIT: begin
          // Write misses merge their word over the freshly filled line.
          if (bus.host_rd_valid) begin
            line_q  <= bus.host_data_bus_read_in;
            valid_q <= 1'b1;
            tag_q   <= req_tag_q;
            if (op_q == OP_WRITE) begin
              line_q[req_pos_q +: WW] <= wdata_q;
              dirty_q                 <= 1'b1;
            end else begin
              bus.common_data_bus_read_in <= bus.host_data_bus_read_in[req_pos_q +: WW];
              bus.rd_valid                <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
